// File: rtl/add_nnbit_multicycle.sv
// Multi-cycle add/subtract: one SLICE_WIDTH slice per clock, with a valid/ready handshake on both sides.
// Optional macro ADD_NNBIT_MULTICYCLE_OVF_EN adds the o_ovf signed-overflow output.
module add_nnbit_multicycle #(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
  input  logic                  i_sub,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry
`ifdef ADD_NNBIT_MULTICYCLE_OVF_EN
  ,
  output logic                  o_ovf
`endif
);

  localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        k_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q, res_q;
  logic                    c_q, cry_q, valid_q, ready_q;
  logic [SLICE_WIDTH-1:0]  sa, sb;
  logic [SLICE_WIDTH:0]    sum;

  // Slice adder shared by every CALC cycle; c_q carries between slices.
  always_comb begin
    sa  = a_q[k_q*SLICE_WIDTH +: SLICE_WIDTH];
    sb  = b_q[k_q*SLICE_WIDTH +: SLICE_WIDTH];
    sum = {1'b0, sa} + {1'b0, sb} + {{SLICE_WIDTH{1'b0}}, c_q};
  end

`ifdef ADD_NNBIT_MULTICYCLE_OVF_EN
  logic ovf_q;
  logic ovf_d;
  // Carry into the MSB is recovered from the MSB sum bit, then XORed with carry-out.
  assign ovf_d = sa[SLICE_WIDTH-1] ^ sb[SLICE_WIDTH-1] ^ sum[SLICE_WIDTH-1] ^ sum[SLICE_WIDTH];
  assign o_ovf = ovf_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cry_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef ADD_NNBIT_MULTICYCLE_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && ready_q) begin
            a_q     <= i_num_a;
            b_q     <= i_sub ? ~i_num_b : i_num_b;
            c_q     <= i_sub ? ~i_cry : i_cry;
            k_q     <= '0;
            ready_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          res_q[k_q*SLICE_WIDTH +: SLICE_WIDTH] <= sum[SLICE_WIDTH-1:0];
          c_q <= sum[SLICE_WIDTH];
          k_q <= k_q + 1'b1;
          if (k_q == LAST_K) begin
            cry_q   <= sum[SLICE_WIDTH];
            valid_q <= 1'b1;
            state_q <= DONE;
`ifdef ADD_NNBIT_MULTICYCLE_OVF_EN
            ovf_q   <= ovf_d;
`endif
          end
        end
        DONE: begin
          // Return to IDLE only; the next transfer is one edge later.
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_res   = res_q;
  assign o_cry   = cry_q;

endmodule

// File: tb/tb_add_nnbit_multicycle.sv
// Self-checking bench for add_nnbit_multicycle (32-bit, 8-bit slices): vector table,
// handshake/reset corner sequences and a randomized back-to-back run against a plain-arithmetic model.
module tb_add_nnbit_multicycle;
  localparam int DW = 32;
  localparam int SW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_num_a = '0;
  logic [DW-1:0] i_num_b = '0;
  logic          i_cry = 1'b0;
  logic          i_sub = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_res;
  logic          o_cry;
  logic          ovf;

  add_nnbit_multicycle #(.DATA_WIDTH(DW), .SLICE_WIDTH(SW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_num_a(i_num_a), .i_num_b(i_num_b), .i_cry(i_cry), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res), .o_cry(o_cry)
`ifdef ADD_NNBIT_MULTICYCLE_OVF_EN
    , .o_ovf(ovf)
`endif
  );
`ifndef ADD_NNBIT_MULTICYCLE_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: wide unsigned sum for result/carry, true signed sum for overflow.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cry, input logic sub);
    logic [31:0] bb;
    longint      cc, u, s, sa, sb;
    bb = sub ? ~b : b;
    cc = (sub ? !cry : cry) ? 1 : 0;
    u  = longint'({32'd0, a}) + longint'({32'd0, bb}) + cc;
    sa = longint'($signed(a));
    sb = longint'($signed(bb));
    s  = sa + sb + cc;
    model = {(s > 64'sd2147483647 || s < -64'sd2147483648), u[32], u[31:0]};
  endfunction

  // Offer operands from IDLE, return edges from transfer to o_valid.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cry,
                          input logic sub, output int lat);
    int w;
    @(negedge i_clk);
    i_num_a = a; i_num_b = b; i_cry = cry; i_sub = sub; i_valid = 1'b1; i_ready = 1'b0;
    w = 0;
    while (!o_ready && w < 50) begin @(negedge i_clk); w++; end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin @(posedge i_clk); #1; lat++; end
  endtask

  task automatic retire();
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        cry, sub;
    logic [31:0] res;
    logic        co, ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, n_ret, cyc, last_x, n_x;
    logic [31:0] r0; logic c0;
    logic [33:0] exp_m;
    logic [33:0] q[$];
    logic ok;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0};
    vecs[4] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h000000FF, 32'h00000001, 1'b1, 1'b0, 32'h00000101, 1'b0, 1'b0};
    vecs[7] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0};

    // Reset state
    #12;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_res", o_res, 0);
    check("rst_cry", o_cry, 0);
    check("rst_ovf", ovf, 0);
    @(negedge i_clk); i_rst_n = 1'b1;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cry, vecs[i].sub, lat);
      check($sformatf("vec%0d_lat", i), lat, 4);
      check($sformatf("vec%0d_res", i), o_res, vecs[i].res);
      check($sformatf("vec%0d_cry", i), o_cry, vecs[i].co);
`ifdef ADD_NNBIT_MULTICYCLE_OVF_EN
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
`endif
      retire();
      check($sformatf("vec%0d_idle", i), {o_valid, o_ready}, 2'b01);
    end

    // Stall in DONE with new operands offered; they must be ignored, also on the retire edge
    start_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
    r0 = o_res; c0 = o_cry;
    exp_m = model(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    check("stall_res0", r0, exp_m[31:0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      i_valid = 1'b1; i_num_a = $urandom; i_num_b = $urandom; i_sub = 1'($urandom);
      @(posedge i_clk); #1;
      check("stall_valid", o_valid, 1);
      check("stall_ready", o_ready, 0);
      check("stall_res", o_res, r0);
      check("stall_cry", o_cry, c0);
    end
    @(negedge i_clk); i_ready = 1'b1;
    @(posedge i_clk); #1;
    check("retire_no_accept", {o_valid, o_ready}, 2'b01);
    i_valid = 1'b0; i_ready = 1'b0;

    // Asynchronous reset during slice 2 of CALC
    @(negedge i_clk);
    i_num_a = 32'hAAAAAAAA; i_num_b = 32'h11111111; i_cry = 1'b0; i_sub = 1'b0; i_valid = 1'b1;
    @(posedge i_clk); #1; i_valid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #2;
    check("pre_rst_res_nonzero", (o_res != 0), 1);
    i_rst_n = 1'b0; #1;
    check("arst_valid", o_valid, 0);
    check("arst_ready", o_ready, 1);
    check("arst_res", o_res, 0);
    @(negedge i_clk); i_rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk); #1;
      if (o_valid || !o_ready) ok = 1'b0;
    end
    check("arst_no_pulse", ok, 1);
    start_op(32'h00000010, 32'h00000020, 1'b0, 1'b0, lat);
    check("post_rst_lat", lat, 4);
    check("post_rst_res", o_res, 32'h00000030);
    retire();

    // Back-to-back with i_valid/i_ready high; operands change every cycle
    n_ret = 0; cyc = 0; last_x = -1; n_x = 0;
    i_valid = 1'b1; i_ready = 1'b1;
    while (n_ret < 1000 && cyc < 7000) begin
      @(negedge i_clk);
      if (o_valid && i_ready) begin
        if (q.size() == 0) check("b2b_underflow", 1, 0);
        else begin
          exp_m = q.pop_front();
          check("b2b_res", o_res, exp_m[31:0]);
          check("b2b_cry", o_cry, exp_m[32]);
`ifdef ADD_NNBIT_MULTICYCLE_OVF_EN
          check("b2b_ovf", ovf, exp_m[33]);
`endif
        end
        n_ret++;
      end
      i_num_a = $urandom; i_num_b = $urandom;
      i_cry = 1'($urandom); i_sub = 1'($urandom);
      if ((n_x % 7) == 3) begin i_num_a = 32'hFFFFFFFF; i_num_b = 32'h00000001; end
      if (o_ready) begin
        q.push_back(model(i_num_a, i_num_b, i_cry, i_sub));
        if (last_x >= 0) check("b2b_spacing", cyc - last_x, 6);
        last_x = cyc; n_x++;
      end
      cyc++;
    end
    check("b2b_count", n_ret, 1000);
    i_valid = 1'b0; i_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
